// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF and MEM ports, absorbing a fixed read latency.
// Optional IF starvation guard is compiled in when ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ACK} state_t;
  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       ack_dm;
  logic       is_store;
  logic       in_ack, arb_open, elig_if, elig_dm, force_if, gnt_if, gnt_dm;

  // The port being acked is masked so the other port can take the slot in the same cycle.
  assign in_ack   = (state == ACK);
  assign arb_open = (state == IDLE) || in_ack;
  assign elig_if  = if_req & ~(in_ack & ~ack_dm);
  assign elig_dm  = dm_req & ~(in_ack & ack_dm);
  assign gnt_dm   = rst_n & arb_open & elig_dm & ~force_if;
  assign gnt_if   = rst_n & arb_open & elig_if & (force_if | ~elig_dm);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;

  always_ff @(posedge clk) begin
    if (!rst_n)                                                starve <= '0;
    else if (gnt_if)                                           starve <= '0;
    else if (gnt_dm && elig_if && starve != SW'(STARVE_MAX))   starve <= starve + SW'(1);
  end

  assign force_if = elig_if && (starve == SW'(STARVE_MAX));
`else
  // STARVE_MAX is always positive, so IF is never forced: strict DM priority.
  assign force_if = (STARVE_MAX < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      ack_dm   <= 1'b0;
      is_store <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (gnt_if | gnt_dm) begin
        cnt      <= 4'd1;
        ack_dm   <= gnt_dm;
        is_store <= gnt_dm & dm_we;
      end else if (state == BUSY_IF || state == BUSY_DM) begin
        cnt <= cnt + 4'd1;
      end
      if (state == BUSY_IF && cnt == LAT4)                 if_rdata <= mem_rdata;
      if (state == BUSY_DM && cnt == LAT4 && !is_store)    dm_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACK: begin
        if (gnt_dm)      state_nxt = BUSY_DM;
        else if (gnt_if) state_nxt = BUSY_IF;
        else             state_nxt = IDLE;
      end
      BUSY_IF, BUSY_DM: if (cnt == LAT4) state_nxt = ACK;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = gnt_if | gnt_dm;
    mem_we    = gnt_dm & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_dm) begin
      mem_addr = dm_addr;
      if (dm_we) mem_wdata = dm_wdata;
    end else if (gnt_if) begin
      mem_addr = if_addr;
    end
    if_ack = rst_n & in_ack & ~ack_dm;
    dm_ack = rst_n & in_ack & ack_dm;
  end

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios pinned with literals, then random traffic
// compared each cycle against a time-based model of grants, acks and registered read data.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2, SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, mem_addr;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0, if_rdata, dm_rdata, mem_wdata;
  logic if_ack, dm_ack, mem_en, mem_we, stall_if, stall_dm;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  typedef struct {
    logic rst_n, if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
  } stim_t;

  int compared = 0, mismatched = 0, cyc = 0;
  stim_t st;
  bit auto_mode = 1'b0, if_busy = 1'b0, dm_busy = 1'b0;

  // memory environment and the model's own view of memory contents
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];
  int            rd_due[$];
  logic [AW-1:0] rd_adr[$];

  // model: owner 0=none 1=IF 2=DM, granted at cycle m_gt
  int m_owner = 0, m_gt = 0, m_starve = 0;
  bit m_store = 1'b0;
  logic [DW-1:0] m_val = '0, m_if_rd = '0, m_dm_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : seed_val(a);
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : seed_val(a);
  endfunction

  task automatic gen_stim();
    st.rst_n = ($urandom_range(0, 249) != 0);
    if (!st.rst_n) begin
      if_busy = 1'b0;
      dm_busy = 1'b0;
    end else begin
      if (!if_busy) begin
        st.if_addr = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 2) == 0) if_busy = 1'b1;
      end
      if (!dm_busy) begin
        st.dm_we    = 1'($urandom_range(0, 1));
        st.dm_addr  = 32'($urandom_range(0, 15)) << 2;
        st.dm_wdata = $urandom;
        if ($urandom_range(0, 2) == 0) dm_busy = 1'b1;
      end
    end
    st.if_req = if_busy;
    st.dm_req = dm_busy;
  endtask

  task automatic step();
    int g;
    bit ack_cyc, el_if, el_dm, frc, e_if_ack, e_dm_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(posedge clk);
    cyc++;
    #1;
    while (rd_due.size() != 0 && rd_due[0] < cyc) begin
      void'(rd_due.pop_front());
      void'(rd_adr.pop_front());
    end
    if (rd_due.size() != 0 && rd_due[0] == cyc) begin
      mem_rdata = env_rd(rd_adr[0]);
      void'(rd_due.pop_front());
      void'(rd_adr.pop_front());
    end else begin
      mem_rdata = $urandom;
    end
    if (auto_mode) gen_stim();
    rst_n = st.rst_n; if_req = st.if_req; if_addr = st.if_addr;
    dm_req = st.dm_req; dm_we = st.dm_we; dm_addr = st.dm_addr; dm_wdata = st.dm_wdata;

    @(negedge clk);
    ack_cyc  = (m_owner != 0) && (cyc == m_gt + LAT + 1);
    e_if_ack = rst_n && ack_cyc && m_owner == 1;
    e_dm_ack = rst_n && ack_cyc && m_owner == 2;
    el_if    = if_req && !(ack_cyc && m_owner == 1);
    el_dm    = dm_req && !(ack_cyc && m_owner == 2);
    frc      = GUARD && el_if && m_starve >= SMAX;
    g = 0;
    if (rst_n && (m_owner == 0 || ack_cyc)) g = frc ? 1 : el_dm ? 2 : el_if ? 1 : 0;
    e_addr  = (g == 2) ? dm_addr : (g == 1) ? if_addr : '0;
    e_wdata = (g == 2 && dm_we) ? dm_wdata : '0;

    chk("mem_en", mem_en, g != 0);
    if (g != 0 || !rst_n) begin
      chk("mem_we", mem_we, g == 2 && dm_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("if_ack", if_ack, e_if_ack);
    chk("dm_ack", dm_ack, e_dm_ack);
    chk("stall_if", stall_if, if_req && !e_if_ack);
    chk("stall_dm", stall_dm, dm_req && !e_dm_ack);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);

    if (mem_en && mem_we)  env_mem[mem_addr] = mem_wdata;
    else if (mem_en) begin
      rd_due.push_back(cyc + LAT);
      rd_adr.push_back(mem_addr);
    end

    if (!rst_n) begin
      m_owner = 0; m_starve = 0; m_if_rd = '0; m_dm_rd = '0;
      if_busy = 1'b0; dm_busy = 1'b0;
    end else begin
      if (m_owner != 0 && cyc == m_gt + LAT) begin
        if (m_owner == 1) m_if_rd = m_val;
        else if (!m_store) m_dm_rd = m_val;
      end
      if (ack_cyc) m_owner = 0;
      if (g == 1) begin
        m_owner = 1; m_gt = cyc; m_store = 1'b0; m_val = mdl_rd(if_addr); m_starve = 0;
      end else if (g == 2) begin
        m_owner = 2; m_gt = cyc; m_store = dm_we;
        if (dm_we) mdl_mem[dm_addr] = dm_wdata;
        else       m_val = mdl_rd(dm_addr);
        if (el_if && m_starve < SMAX) m_starve++;
      end
      if (e_if_ack) if_busy = 1'b0;
      if (e_dm_ack) dm_busy = 1'b0;
    end
  endtask

  initial begin
    st = '{default: '0};
    env_mem[32'h40] = 32'h8C220004; mdl_mem[32'h40] = 32'h8C220004;
    env_mem[32'h20] = 32'h12345678; mdl_mem[32'h20] = 32'h12345678;
    env_mem[32'h44] = 32'h0BADF00D; mdl_mem[32'h44] = 32'h0BADF00D;

    // reset: everything zero
    st.rst_n = 1'b0;
    step();
    chk("rst_mem_en", mem_en, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_dm_rdata", dm_rdata, 0);
    step();
    st.rst_n = 1'b1;
    step();

    // single fetch
    st.if_req = 1'b1; st.if_addr = 32'h40;
    step();
    chk("t1_mem_en", mem_en, 1); chk("t1_mem_addr", mem_addr, 32'h40); chk("t1_mem_we", mem_we, 0);
    step(); chk("t1_stall2", stall_if, 1);
    step(); chk("t1_stall3", stall_if, 1);
    step();
    chk("t1_if_ack", if_ack, 1); chk("t1_if_rdata", if_rdata, 32'h8C220004); chk("t1_stall4", stall_if, 0);
    st.if_req = 1'b0;
    step();
    chk("t1_ack_pulse", if_ack, 0); chk("t1_rdata_held", if_rdata, 32'h8C220004);

    // store
    st.dm_req = 1'b1; st.dm_we = 1'b1; st.dm_addr = 32'h10; st.dm_wdata = 32'hDEADBEEF;
    step();
    chk("t2_mem_we", mem_we, 1); chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF); chk("t2_mem_addr", mem_addr, 32'h10);
    step(); step(); step();
    chk("t2_dm_ack", dm_ack, 1); chk("t2_dm_rdata", dm_rdata, 0);
    st.dm_req = 1'b0; st.dm_we = 1'b0;
    step();

    // collision: DM first, IF takes the ack cycle
    st.if_req = 1'b1; st.if_addr = 32'h44; st.dm_req = 1'b1; st.dm_addr = 32'h20;
    step();
    chk("t3_mem_addr", mem_addr, 32'h20);
    step(); step(); step();
    chk("t3_dm_ack", dm_ack, 1); chk("t3_dm_rdata", dm_rdata, 32'h12345678);
    chk("t3_if_mem_en", mem_en, 1); chk("t3_if_addr", mem_addr, 32'h44);
    st.dm_req = 1'b0;
    step(); step(); step();
    chk("t3_if_ack", if_ack, 1); chk("t3_if_rdata", if_rdata, 32'h0BADF00D);
    st.if_req = 1'b0;
    step();

    // reset mid-access
    st.if_req = 1'b1; st.if_addr = 32'h40;
    step();
    st.rst_n = 1'b0; st.if_req = 1'b0;
    step();
    chk("t5_mem_en", mem_en, 0);
    st.rst_n = 1'b1;
    step(); chk("t5_if_rdata", if_rdata, 0); chk("t5_no_ack3", if_ack, 0);
    step(); chk("t5_no_ack4", if_ack, 0);
    st.if_req = 1'b1;
    step(); step(); step(); step();
    chk("t5_new_ack", if_ack, 1); chk("t5_new_rdata", if_rdata, 32'h8C220004);
    st.if_req = 1'b0;
    step();

    auto_mode = 1'b1;
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
